// File: rtl/gate_exerciser.sv
// gate_exerciser: drives a two-input gate through all four input vectors,
// holds each for HOLD cycles, samples the gate output at the end of each
// hold window and reports a per-vector fail mask plus an overall pass flag.
module gate_exerciser #(
   parameter int unsigned HOLD  = 10,
   parameter logic [3:0]  TRUTH = 4'b1110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       gate_out,
   output logic       in1,
   output logic       in2,
   output logic [1:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask
);

   localparam int unsigned   CW   = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

   typedef enum logic {
      IDLE,
      DRIVE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          mismatch;
   logic [3:0]    fail_next;
   logic [1:0]    vec_next;

   // Sample-edge compare: case-inequality so an X/Z gate output counts as a mismatch.
   always_comb begin
      mismatch  = (gate_out !== TRUTH[vec_idx]);
      fail_next = fail_mask | ({3'b000, mismatch} << vec_idx);
      vec_next  = vec_idx + 2'd1;
   end

   // Sequencer: IDLE waits for start, DRIVE steps through the vectors with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         vec_idx   <= '0;
         in1       <= 1'b0;
         in2       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= DRIVE;
                  cnt       <= '0;
                  vec_idx   <= '0;
                  in1       <= 1'b0;
                  in2       <= 1'b0;
                  busy      <= 1'b1;
                  pass      <= 1'b0;
                  fail_mask <= '0;
               end
            end
            DRIVE: begin
               if (cnt != LAST) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  fail_mask <= fail_next;
                  cnt       <= '0;
                  if (vec_idx != 2'd3) begin
                     vec_idx <= vec_next;
                     in1     <= vec_next[1];
                     in2     <= vec_next[0];
                  end else begin
                     state   <= IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     pass    <= (fail_next == 4'b0000);
                     vec_idx <= '0;
                     in1     <= 1'b0;
                     in2     <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: directed and randomized runs of gate_exerciser against a
// behavioural model of the run timeline and expected fail mask.
module tb_gate_exerciser;

   localparam int unsigned H = 10;
   localparam logic [3:0]  TT = 4'b1110;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       gate_out;
   logic       in1, in2, busy, done, pass;
   logic [1:0] vec_idx;
   logic [3:0] fail_mask;

   // Behaviour of the gate under test: a lookup table indexed by {in1,in2},
   // optionally inverted to model glitches or a wrong sample.
   logic [3:0] gtab = 4'b1110;
   logic       glitch = 1'b0;

   int tests = 0;
   int fails = 0;

   assign gate_out = gtab[{in1, in2}] ^ glitch;

   always #5 clk = ~clk;

   gate_exerciser #(.HOLD(H), .TRUTH(TT)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .gate_out (gate_out),
      .in1      (in1),
      .in2      (in2),
      .vec_idx  (vec_idx),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .fail_mask(fail_mask)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_in1"}, in1, 0);
      check({tag, "_in2"}, in2, 0);
      check({tag, "_vec"}, vec_idx, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_mask"}, fail_mask, 0);
   endtask

   // One run: start is presented before edge 0, then every edge e = 0..4H is
   // checked against the timeline model. gmode 1 inverts the gate during the
   // first H-1 cycles of vector 1; gmode 2 inverts it only on vector 1's sample
   // edge. abort_at >= 0 asserts rst so that it is sampled at that edge.
   task automatic run(input string tag, input logic [3:0] gt, input int gmode,
                      input bit pulses, input bit keep_start, input int abort_at);
      logic [3:0] exp_mask;
      logic [3:0] seen;
      int         v;
      gtab     = gt;
      glitch   = 1'b0;
      start    = 1'b1;
      exp_mask = (gt ^ TT) ^ ((gmode == 2) ? 4'b0010 : 4'b0000);
      for (int e = 0; e <= 4 * int'(H); e++) begin
         step();
         v = (e < 4 * int'(H)) ? e / int'(H) : 0;
         seen = 4'b0000;
         for (int k = 0; k < 4; k++)
            if ((k + 1) * int'(H) <= e) seen[k] = 1'b1;
         check({tag, "_busy"}, busy, (e < 4 * int'(H)));
         check({tag, "_done"}, done, (e == 4 * int'(H)));
         check({tag, "_vec"}, vec_idx, v);
         check({tag, "_in1"}, in1, (v >> 1) & 1);
         check({tag, "_in2"}, in2, v & 1);
         check({tag, "_mask"}, fail_mask, exp_mask & seen);
         check({tag, "_pass"}, pass, (e == 4 * int'(H)) && (exp_mask == 4'b0000));
         start  = keep_start && (e >= 38) ||
                  pulses && (e == 14 || e == 38);
         glitch = (gmode == 1) ? (e >= int'(H) && e <= 2 * int'(H) - 2) :
                  (gmode == 2) ? (e == 2 * int'(H) - 1) : 1'b0;
         if (e == abort_at - 1) begin
            rst = 1'b1;
            step();
            check_idle_reset({tag, "_abort"});
            rst    = 1'b0;
            start  = 1'b0;
            glitch = 1'b0;
            step();
            check({tag, "_abort_nodone"}, done, 0);
            check({tag, "_abort_idle"}, busy, 0);
            return;
         end
      end
      glitch = 1'b0;
   endtask

   initial begin
      logic [3:0] r;
      logic [3:0] m;
      // Reset state
      step();
      step();
      check_idle_reset("reset");
      rst = 1'b0;
      step();
      check_idle_reset("idle_no_start");

      // Good OR gate, stuck-at-0, AND gate in place of OR
      run("or_good", 4'b1110, 0, 0, 0, -1);
      step();
      check("or_hold_pass", pass, 1);
      check("or_hold_done", done, 0);
      run("stuck0", 4'b0000, 0, 0, 0, -1);
      check("stuck0_mask", fail_mask, 4'b1110);
      run("and_gate", 4'b1000, 0, 0, 0, -1);
      check("and_mask", fail_mask, 4'b0110);
      step();
      check("and_hold_mask", fail_mask, 4'b0110);
      check("and_hold_pass", pass, 0);

      // Start pulses while busy are ignored; start held through done restarts
      run("busy_start", 4'b1110, 0, 1, 1, -1);
      run("restart", 4'b1110, 0, 0, 0, -1);

      // Reset mid-run, then a fresh full run
      run("abort", 4'b0000, 0, 0, 0, 20);
      run("after_abort", 4'b1110, 0, 0, 0, -1);

      // Glitch inside the hold window vs. wrong value on the sample edge
      run("glitch_early", 4'b1110, 1, 0, 0, -1);
      run("glitch_sample", 4'b1110, 2, 0, 0, -1);
      check("glitch_sample_mask", fail_mask, 4'b0010);

      // Randomized gate tables
      for (int i = 0; i < 8; i++) begin
         r = 4'($urandom_range(0, 15));
         m = r ^ TT;
         run("rand", r, 0, 0, 0, -1);
         check("rand_final_mask", fail_mask, m);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
